disp_arbiter: RTL
=================

# disp_arbiter

- Time-shares the board's two-digit seven-segment display between two requesters.
- Generates the digit-select scan (CA) and the 4-bit nibble fed to the existing `disp_mod` decoder.
- Grants the display with a registered request/grant handshake and round-robin fairness.
- Sits between the state machines that want to show an 8-bit value and the display decoder.

## Interface
- SCAN_DIV, 1_250_000: clock cycles per digit half-frame (CA toggle period); must be ≥ 2.
- HOLD_FRAMES, 4: full frames an owner keeps the display while the other requester is waiting; must be ≥ 1.
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  reset, synchronous, active-high.
- REQ  input  2  REQ[k] = requester k wants the display; level, held while wanted.
- VAL0  input  8  requester 0 value; [3:0] low digit, [7:4] high digit.
- VAL1  input  8  requester 1 value, same layout.
- GNT  output  2  one-hot grant, registered; 2'b00 when idle.
- CA  output  1  digit select; 0 = low digit shown, 1 = high digit shown.
- DIGIT  output  4  nibble to `disp_mod`.
- BLANK  output  1  high when no owner; downstream display is dark.

## Operation
**Scan counter**
- `cnt` counts 0..SCAN_DIV-1 and wraps.
- `tick` = (cnt == SCAN_DIV-1). On `tick`, CA toggles.
- `frame_end` = tick while CA == 1.
- The counter runs in every state and is never stalled by arbitration.

**State machine** (IDLE, SHOW), with registers:
- `owner` (1 bit), the current grantee.
- `rr` (1 bit), the requester with priority on the next contested decision.
- `frm`, the frame count of the current ownership, saturating at HOLD_FRAMES-1.
- `shadow[7:0]`, the latched value being displayed.

**IDLE**
- Evaluated every cycle.
- If REQ != 0: grant the requester, choosing `rr` if both are requesting.
- On a grant: `owner` = k, `shadow` = VALk, `frm` = 0, `rr` = ~k, go to SHOW.
- Otherwise stay in IDLE.

**SHOW**
- Evaluated only on `frame_end`; between frame ends, GNT and `shadow` are frozen.
- Owner's REQ low, other requesting: switch to the other requester (load `shadow` from its VAL, `frm` = 0, `rr` = ~new owner).
- Owner's REQ low, other not requesting: go to IDLE; GNT becomes 0.
- Owner's REQ high, other requesting, `frm` == HOLD_FRAMES-1: switch, as above.
- Any other case: keep the owner, `shadow` = VAL[owner] (refresh), `frm` = min(`frm`+1, HOLD_FRAMES-1).

**Outputs**
- GNT[k] = (state == SHOW && `owner` == k).
- BLANK = (state == IDLE).
- DIGIT = BLANK ? 4'h0 : (CA ? shadow[7:4] : shadow[3:0]).
- DIGIT is combinational from registers only; there is no path from REQ or VAL to the outputs.

**Boundary conditions**
- A requester dropping REQ mid-frame keeps GNT until that `frame_end`, so every frame shown is complete.
- VAL changes mid-frame are not displayed until the next `frame_end` refresh, which prevents tearing.
- A single requester holds the display indefinitely; `frm` saturates.
- REQ=2'b11 in IDLE with `rr`=0 grants requester 0.

## Timing
- Reset values: state = IDLE, GNT = 2'b00, CA = 0, cnt = 0, DIGIT = 4'h0, BLANK = 1, `rr` = 0, `frm` = 0, `shadow` = 8'h00.
- RST asserted mid-operation returns every register to its reset value on that same rising edge, regardless of `tick` or REQ.
- Grant latency from IDLE: REQ sampled high on edge n gives GNT, BLANK = 0 and the new DIGIT after edge n.
- The first frame after a grant from IDLE may be partial, because CA is free-running.
- Switch and release take effect on the edge where `frame_end` is true; the new GNT and CA = 0 appear together.
- Full frame = 2·SCAN_DIV cycles.
- A waiting requester is granted within at most HOLD_FRAMES·2·SCAN_DIV cycles after the owner's grant.

## Test plan
All scenarios use SCAN_DIV=4 and HOLD_FRAMES=2, so one frame is 8 cycles.
- **Reset:** hold RST 3 cycles with REQ=2'b11. Expect GNT=00, BLANK=1, DIGIT=0, CA=0. Release RST; expect CA toggling every 4 cycles.
- **Single requester:** REQ=01, VAL0=8'hA5. Expect GNT=01 one cycle later. DIGIT must be 5 while CA=0 and A while CA=1, sustained indefinitely with no switch.
- **Contention:** REQ=11 from IDLE. Expect requester 0 for 2 frames. At the second `frame_end`, expect GNT=10 and DIGIT showing VAL1. After 2 more frames, expect GNT=01.
- **Early release:** owner 1 drops REQ mid-frame while REQ[0]=0. Expect GNT to stay 10 until `frame_end`, then GNT=00 and BLANK=1 on that edge.
- **No tearing:** change VAL0 from 8'h12 to 8'h34 while CA=1. Expect DIGIT=1 for the rest of the frame, then 4 at the next frame.
- **Reset mid-grant:** assert RST while GNT=10 and CA=1. Expect all reset values on the next edge.

Source files
------------

// File: rtl/disp_arbiter.sv
// disp_arbiter: round-robin owner of the two-digit seven-segment display.
// Drives the free-running digit scan and the nibble fed to disp_mod.
module disp_arbiter #(
  parameter int SCAN_DIV    = 1_250_000,
  parameter int HOLD_FRAMES = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] REQ,
  input  logic [7:0] VAL0,
  input  logic [7:0] VAL1,
  output logic [1:0] GNT,
  output logic       CA,
  output logic [3:0] DIGIT,
  output logic       BLANK
);
  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CW-1:0] CMAX = CW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FMAX = FW'(HOLD_FRAMES - 1);

  typedef enum logic {IDLE, SHOW} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q;
  logic          ca_q;
  logic          owner_q, owner_d;
  logic          rr_q, rr_d;
  logic [FW-1:0] frm_q, frm_d;
  logic [7:0]    shadow_q, shadow_d;
  logic          tick, frame_end, k, mine, other, sw;

  assign tick      = (cnt_q == CMAX);
  assign frame_end = tick && ca_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q    <= '0;
      ca_q     <= 1'b0;
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      rr_q     <= 1'b0;
      frm_q    <= '0;
      shadow_q <= 8'h00;
    end else begin
      cnt_q    <= tick ? '0 : cnt_q + CW'(1);
      ca_q     <= ca_q ^ tick;
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      frm_q    <= frm_d;
      shadow_q <= shadow_d;
    end
  end

  // Ownership only changes on a frame boundary once granted, so frames are never cut short.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    frm_d    = frm_q;
    shadow_d = shadow_q;
    k        = (REQ == 2'b11) ? rr_q : REQ[1];
    mine     = REQ[owner_q];
    other    = REQ[~owner_q];
    sw       = other && (!mine || frm_q == FMAX);
    if (state_q == IDLE) begin
      if (|REQ) begin
        state_d  = SHOW;
        owner_d  = k;
        shadow_d = k ? VAL1 : VAL0;
        frm_d    = '0;
        rr_d     = ~k;
      end
    end else if (frame_end) begin
      if (sw) begin
        owner_d  = ~owner_q;
        shadow_d = owner_q ? VAL0 : VAL1;
        frm_d    = '0;
        rr_d     = owner_q;
      end else if (!mine) begin
        state_d = IDLE;
      end else begin
        shadow_d = owner_q ? VAL1 : VAL0;
        frm_d    = (frm_q == FMAX) ? frm_q : frm_q + FW'(1);
      end
    end
  end

  assign GNT   = (state_q == SHOW) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign BLANK = (state_q == IDLE);
  assign CA    = ca_q;
  assign DIGIT = BLANK ? 4'h0 : (ca_q ? shadow_q[7:4] : shadow_q[3:0]);
endmodule
